// File: rtl/mash_trunc_stage.sv
// Parametrised MASH quantiser stage: truncate / error-feedback / round with saturation counting.
// Optional LFSR dither in modes 1 and 2 is enabled by defining MASH_TRUNC_DITHER_EN.
module mash_trunc_stage #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clck,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IN_W-1:0]         x_in,
  input  logic [1:0]              mode,
  input  logic                    clr_err,
  output logic [OUT_W-1:0]        y_out,
  output logic [IN_W-OUT_W-1:0]   e_out,
  output logic                    out_valid,
  output logic                    sat,
  output logic [CNT_W-1:0]        sat_cnt
);

  localparam int unsigned E_W = IN_W - OUT_W;
  localparam int unsigned S_W = IN_W + 1;

  localparam logic [S_W-1:0]  RND_TERM = {{(S_W-E_W){1'b0}}, 1'b1, {(E_W-1){1'b0}}};
  localparam logic [IN_W-1:0] Q_MAX    = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] Q_MIN    = {1'b1, {(IN_W-1){1'b0}}};

  logic [E_W-1:0]  e_reg;
  logic [1:0]      mode_reg;
  logic            fb_en;
  logic [S_W-1:0]  add_term;
  logic [S_W-1:0]  dith_term;
  logic [S_W-1:0]  sum;
  logic            sat_hit;
  logic [IN_W-1:0] q;

`ifdef MASH_TRUNC_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; seed is non-zero so the register never locks up
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clck) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else if (in_valid) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  always_comb begin
    dith_term = '0;
    if (mode == 2'd1 || mode == 2'd2) begin
      dith_term = {{(S_W-1){1'b0}}, lfsr[0]};
    end
  end
`else
  assign dith_term = '0;
`endif

  // Residue feedback is suppressed on a mode switch or a same-edge clear
  assign fb_en = (mode == 2'd1) && (mode == mode_reg) && !clr_err;

  always_comb begin
    add_term = '0;
    case (mode)
      2'd1:    add_term = fb_en ? {{(S_W-E_W){1'b0}}, e_reg} : '0;
      2'd2:    add_term = RND_TERM;
      default: add_term = '0;
    endcase
  end

  assign sum = {x_in[IN_W-1], x_in} + add_term + dith_term;

  // Top two bits disagree exactly when the sum left the IN_W signed range
  always_comb begin
    sat_hit = sum[S_W-1] ^ sum[S_W-2];
    q       = sum[IN_W-1:0];
    if (sat_hit) begin
      q = sum[S_W-1] ? Q_MIN : Q_MAX;
    end
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      y_out     <= '0;
      e_out     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      sat_cnt   <= '0;
      e_reg     <= '0;
      mode_reg  <= '0;
    end else begin
      out_valid <= in_valid;
      if (clr_err) begin
        e_reg   <= '0;
        sat_cnt <= '0;
      end
      if (in_valid) begin
        y_out    <= q[IN_W-1:E_W];
        e_out    <= q[E_W-1:0];
        sat      <= sat_hit;
        mode_reg <= mode;
        e_reg    <= (mode == 2'd1) ? q[E_W-1:0] : '0;
        // Increment lands after any same-edge clear and sticks at all-ones
        if (sat_hit) begin
          if (clr_err) begin
            sat_cnt <= CNT_W'(1);
          end else if (!(&sat_cnt)) begin
            sat_cnt <= CNT_W'(sat_cnt + 1'b1);
          end
        end
      end
    end
  end

endmodule

// File: doc/mash_trunc_stage.md
Name: mash_trunc_stage

Overview:
Parametrised quantiser stage for the MASH sigma-delta DAC path. It generalises the fixed 16-to-3-bit truncator to arbitrary input/output widths and adds a registered valid handshake and three quantisation modes: plain truncation, first-order error feedback, and round-to-nearest. It also provides saturation detection with a sticky event counter. It sits between the MASH integrator chain and the multi-bit DAC/next-stage combiner, and its e_out feeds the following MASH stage.

Parameters:
IN_W, 16, signed input width (>= OUT_W+2)
OUT_W, 3, signed quantised output width
E_W, IN_W-OUT_W, error/residue width (derived localparam, not overridable)
CNT_W, 8, saturation counter width

Ports:
clck  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low; sampled on rising clck
in_valid  input  1  x_in/mode qualify this cycle
x_in  input  IN_W  signed sample
mode  input  2  0=truncate, 1=error feedback, 2=round, 3=reserved (acts as 0)
clr_err  input  1  synchronous clear of feedback residue and sat_cnt
y_out  output  OUT_W  signed quantised sample
e_out  output  E_W  unsigned residue (LSBs of quantised sum)
out_valid  output  1  y_out/e_out/sat valid
sat  output  1  current output beat was saturated
sat_cnt  output  CNT_W  saturating count of saturated beats

Behaviour:
- Reset (rst==0 at clck edge): y_out=0, e_out=0, out_valid=0, sat=0, sat_cnt=0, e_reg=0, mode_reg=0. Reset has priority over everything, including mid-stream beats; a beat presented during reset is dropped.
- Latency is 1 cycle. A beat accepted at edge N (in_valid=1) appears at edge N with out_valid=1 visible in cycle N+1. out_valid=0 on any edge without in_valid. Outputs hold their last values when out_valid=0.
- Sum s is formed at IN_W+1 bits, signed:
  - mode 0/3: s = x_in
  - mode 1: s = x_in + zero-extended e_reg
  - mode 2: s = x_in + 2^(E_W-1)
- Saturation: if s > 2^(IN_W-1)-1, clamp to that value; if s < -2^(IN_W-1), clamp to that value. On a clamp, sat=1 for that beat and sat_cnt increments, sticking at 2^CNT_W-1 without wrapping.
- Output split of clamped q: y_out = q[IN_W-1:E_W] (arithmetic floor) and e_out = q[E_W-1:0].
- e_reg loads e_out only on valid beats in mode 1. In all other modes e_reg is loaded with 0.
- Mode change: if a valid beat has a mode different from mode_reg, the feedback term is forced to 0 for that beat. mode_reg updates on every valid beat.
- clr_err=1: e_reg and sat_cnt are cleared at the edge. If in_valid is also 1 on the same edge, the beat is processed with feedback 0. The resulting sat increment is applied after the clear, so sat_cnt=1 if that beat saturates.
- No back-pressure: the downstream stage must accept every out_valid beat.

Optional Feature:
MASH_TRUNC_DITHER_EN
- Defined: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1; never all-zero). In modes 1 and 2, lfsr[0] is added to s at bit 0 before saturation. The LFSR advances on each valid beat only.
- Undefined: no LFSR logic exists, and behaviour is exactly as above.
- All test values below assume the macro is undefined.

Test Plan:
1. Reset: rst=0 for 2 edges while in_valid=1, x_in=100 -> y_out=0, e_out=0, out_valid=0, sat_cnt=0. Release, no valid -> out_valid stays 0.
2. Truncate, defaults: mode=0, x_in=3 then -1 -> (y_out=0, e_out=3) then (y_out=-1, e_out=8191), each with 1-cycle latency.
3. Error feedback: mode=1, x_in=4096 held for 4 beats -> y_out sequence 0,1,0,1 and e_out 4096,0,4096,0. Toggle to mode=0 -> next beat uses no feedback.
4. Saturation: mode=1, x_in=32767 for 3 beats -> beat1 y_out=3, e_out=8191, sat=0; beats 2 and 3 sat=1, y_out=3, e_out=8191; sat_cnt=2. Then CNT_W=2 run of 5 saturated beats -> sat_cnt sticks at 3.
5. Rounding: mode=2, x_in=4096 -> y_out=1, e_out=0; x_in=4095 -> y_out=0, e_out=8191.
6. clr_err with in_valid in mode 1 after e_reg=4096, x_in=4096 -> y_out=0, e_out=4096, and sat_cnt cleared to 0.
